// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a single-outstanding-request instruction memory
// port and presents registered IR/PC/PC_PLUS4/VALID to decode, with a skid slot for stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_IR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] pend_pc, pend_pc_nxt;
  logic [31:0] skid_ir, skid_ir_nxt;
  logic [31:0] skid_pc, skid_pc_nxt;
  logic        load_fetch, load_skid;
  logic [31:0] target;

  assign target    = {br_target[31:2], 2'b00};
  assign imem_addr = fetch_pc;

  // NOTE: every variable driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    pend_pc_nxt  = pend_pc;
    skid_ir_nxt  = skid_ir;
    skid_pc_nxt  = skid_pc;
    load_fetch   = 1'b0;
    load_skid    = 1'b0;
    imem_req     = 1'b0;
    unique case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (br_taken) begin
            fetch_pc_nxt = target;
          end else begin
            fetch_pc_nxt = fetch_pc + 32'd4;
            if (stall) begin
              skid_ir_nxt = imem_rdata;
              skid_pc_nxt = fetch_pc;
              state_nxt   = HOLD;
            end else begin
              load_fetch = 1'b1;
            end
          end
        end else if (br_taken) begin
          // Request already issued to the old address: let it complete, then redirect.
          pend_pc_nxt = target;
          state_nxt   = DRAIN;
        end
      end
      HOLD: begin
        if (br_taken) begin
          fetch_pc_nxt = target;
          state_nxt    = FETCH;
        end else if (!stall) begin
          load_skid = 1'b1;
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          fetch_pc_nxt = br_taken ? target : pend_pc;
          state_nxt    = FETCH;
        end else if (br_taken) begin
          pend_pc_nxt = target;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_VEC;
      pend_pc  <= '0;
      skid_ir  <= '0;
      skid_pc  <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      pend_pc  <= pend_pc_nxt;
      skid_ir  <= skid_ir_nxt;
      skid_pc  <= skid_pc_nxt;
    end
  end

  // Decode-facing registers: kill beats hold, hold beats load; PC/PC_PLUS4 persist across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir       <= NOP_IR;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (flush || br_taken) begin
      ir    <= NOP_IR;
      valid <= 1'b0;
    end else if (stall) begin
      ir    <= ir;
      valid <= valid;
    end else if (load_fetch) begin
      ir       <= imem_rdata;
      pc       <= fetch_pc;
      pc_plus4 <= fetch_pc + 32'd4;
      valid    <= 1'b1;
    end else if (load_skid) begin
      ir       <= skid_ir;
      pc       <= skid_pc;
      pc_plus4 <= skid_pc + 32'd4;
      valid    <= 1'b1;
    end else begin
      ir    <= NOP_IR;
      valid <= 1'b0;
    end
  end

endmodule
